// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the load/store data memory.
//   funct3_e : RV32 load/store width encodings
//   state_e  : LSU control FSM states
//   size_bytes / byte_mask / f3_legal : access decode helpers
package dmem_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BEAT2,
    S_RESP
  } state_e;

  // Byte count for funct3[1:0]; 0 flags the illegal encoding.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      2'b10:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // Lane mask across the {hi,lo} word pair for an access of size sz at offset off.
  function automatic logic [7:0] byte_mask(input logic [1:0] sz, input logic [1:0] off);
    logic [7:0] base;
    case (sz)
      2'b00:   base = 8'b0000_0001;
      2'b01:   base = 8'b0000_0011;
      2'b10:   base = 8'b0000_1111;
      default: base = 8'b0000_0000;
    endcase
    return base << off;
  endfunction

  // Loads: 000,001,010,100,101. Stores: 000,001,010.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (f3[1:0] == 2'b11) return 1'b0;
    if (f3[2] && (we || f3[1])) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// dmem_bank: 2**AW x 32 word array, one synchronous read/write port with
// per-byte write enable. Write-first: rdata returns the merged word on a write.
// Contents are not reset. rdata holds its value while en is low.
//   clk, en, we, be[3:0], addr[AW-1:0], wdata[31:0] -> rdata[31:0]
module dmem_bank #(
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];
  logic [31:0] merged;

  always_comb begin
    merged = mem[addr];
    for (int b = 0; b < 4; b++)
      if (we && be[b]) merged[8*b +: 8] = wdata[8*b +: 8];
  end

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= merged;
      rdata <= merged;
    end
  end

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: valid/ready load/store unit over a synchronous word array.
// Handles RV32 byte/half/word loads (sign/zero extend) and stores; misaligned
// accesses crossing a word boundary take two beats (word w, then w+1, wrapping).
//   clk, rst (sync, active high)
//   req_valid/req_ready, req_we, req_funct3, req_addr[ADDR_W-1:0], req_wdata
//   rsp_valid/rsp_ready, rsp_rdata, rsp_err
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int ADDR_W         = 9,
  parameter bit MISALIGN_SPLIT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int WW = ADDR_W - 2;

  state_e state, state_n;
  logic   accept;

  // request decode (only meaningful in the accept cycle)
  logic [1:0]    off, sz;
  logic [WW-1:0] widx;
  logic          misal, err_now, cross_now;
  logic [7:0]    mask;
  logic [63:0]   wd64;

  assign off  = req_addr[1:0];
  assign widx = req_addr[ADDR_W-1:2];
  assign sz   = req_funct3[1:0];
  assign misal     = (sz == 2'b01 && off[0]) || (sz == 2'b10 && off != 2'b00);
  assign err_now   = !f3_legal(req_we, req_funct3) || (!MISALIGN_SPLIT && misal);
  assign cross_now = !err_now && (({2'b00, off} + {1'b0, size_bytes(sz)}) > 4'd4);
  assign mask = byte_mask(sz, off);
  assign wd64 = {32'b0, req_wdata} << {off, 3'b000};

  // latched request
  logic          we_q, err_q, cross_q;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic [WW-1:0] widx_q;
  logic [31:0]   whi_q, lo_q;
  logic [3:0]    bhi_q;

  // bank port
  logic          bk_en, bk_we;
  logic [3:0]    bk_be;
  logic [WW-1:0] bk_addr;
  logic [31:0]   bk_wdata, bk_rdata;

  always_comb begin
    state_n   = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      S_IDLE:  req_ready = 1'b1;
      S_BEAT2: state_n = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        req_ready = rsp_ready;
        if (rsp_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (rst) req_ready = 1'b0;
    accept = req_valid && req_ready;
    if (accept) state_n = cross_now ? S_BEAT2 : S_RESP;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q <= 1'b0; err_q <= 1'b0; cross_q <= 1'b0; f3_q <= 3'b0;
      off_q <= 2'b0; widx_q <= '0; whi_q <= 32'b0; bhi_q <= 4'b0; lo_q <= 32'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        err_q   <= err_now;
        cross_q <= cross_now;
        f3_q    <= req_funct3;
        off_q   <= off;
        widx_q  <= widx;
        whi_q   <= wd64[63:32];
        bhi_q   <= mask[7:4];
      end
      // beat-1 word is on the bank output during BEAT2
      if (state == S_BEAT2) lo_q <= bk_rdata;
    end
  end

  // Beat 2 is gated by rst so a reset in that cycle leaves only beat-1 bytes written.
  always_comb begin
    bk_en    = 1'b0;
    bk_we    = 1'b0;
    bk_be    = 4'b0;
    bk_addr  = widx;
    bk_wdata = wd64[31:0];
    if (accept) begin
      bk_en = 1'b1;
      bk_we = req_we && !err_now;
      bk_be = mask[3:0];
    end else if (state == S_BEAT2 && !rst) begin
      bk_en    = 1'b1;
      bk_we    = we_q;
      bk_be    = bhi_q;
      bk_addr  = widx_q + {{(WW-1){1'b0}}, 1'b1};
      bk_wdata = whi_q;
    end
  end

  dmem_bank #(.AW(WW)) u_bank (
    .clk   (clk),
    .en    (bk_en),
    .we    (bk_we),
    .be    (bk_be),
    .addr  (bk_addr),
    .wdata (bk_wdata),
    .rdata (bk_rdata)
  );

  // The bank holds its output while idle, so the response stays stable under
  // backpressure without a separate data register. Non-crossing: both halves
  // are the single beat word.
  logic [63:0] pair;
  logic [31:0] sh, ext;

  assign pair = {bk_rdata, cross_q ? lo_q : bk_rdata};
  assign sh   = pair[{off_q, 3'b000} +: 32];

  always_comb begin
    ext = 32'b0;
    case (funct3_e'(f3_q))
      F3_B:    ext = {{24{sh[7]}}, sh[7:0]};
      F3_H:    ext = {{16{sh[15]}}, sh[15:0]};
      F3_W:    ext = sh;
      F3_BU:   ext = {24'b0, sh[7:0]};
      F3_HU:   ext = {16'b0, sh[15:0]};
      default: ext = 32'b0;
    endcase
  end

  assign rsp_rdata = (state == S_RESP && !we_q && !err_q) ? ext : 32'b0;
  assign rsp_err   = (state == S_RESP) && err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        v0, v1, we, rsp_ready;
  logic [2:0]  f3;
  logic [8:0]  addr;
  logic [31:0] wd;
  logic        rr0, rr1, rv0, rv1, re0, re1;
  logic [31:0] rd0, rd1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmem_lsu #(.ADDR_W(9), .MISALIGN_SPLIT(1'b1)) u_split (
    .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rr0), .req_we(we),
    .req_funct3(f3), .req_addr(addr), .req_wdata(wd), .rsp_valid(rv0),
    .rsp_ready(rsp_ready), .rsp_rdata(rd0), .rsp_err(re0)
  );

  dmem_lsu #(.ADDR_W(9), .MISALIGN_SPLIT(1'b0)) u_strict (
    .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rr1), .req_we(we),
    .req_funct3(f3), .req_addr(addr), .req_wdata(wd), .rsp_valid(rv1),
    .rsp_ready(rsp_ready), .rsp_rdata(rd1), .rsp_err(re1)
  );

  typedef struct {
    bit          which;   // 0 = split DUT, 1 = strict DUT
    bit          we;
    logic [2:0]  f3;
    logic [8:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit w, bit st, logic [2:0] f, logic [8:0] a, logic [31:0] d,
                              logic [31:0] er, bit ee, int el);
    vec_t x;
    x.which = w; x.we = st; x.f3 = f; x.addr = a; x.wd = d;
    x.exp_rd = er; x.exp_err = ee; x.exp_lat = el;
    return x;
  endfunction

  // One request with rsp_ready high; lat = cycles from accept to rsp_valid.
  task automatic xact(input bit w, input bit st, input logic [2:0] f, input logic [8:0] a,
                      input logic [31:0] d, output logic [31:0] rd, output logic e, output int lat);
    int n;
    @(negedge clk);
    we = st; f3 = f; addr = a; wd = d;
    if (w) v1 = 1'b1; else v0 = 1'b1;
    n = 0;
    while (!(w ? rr1 : rr0) && n < 10) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    v0 = 1'b0; v1 = 1'b0;
    lat = 0; rd = 32'hx; e = 1'bx;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (w ? rv1 : rv0) begin
        lat = k; rd = w ? rd1 : rd0; e = w ? re1 : re0;
        break;
      end
    end
    if (lat == 0) lat = 99;
  endtask

  logic [31:0] grd;
  logic        gerr;
  int          glat;

  initial begin
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; we = 1'b0; f3 = 3'b0; addr = 9'h0; wd = 32'h0;
    rsp_ready = 1'b1;

    // split DUT (MISALIGN_SPLIT=1)
    vt.push_back(mk(0, 1, 3'b010, 9'h010, 32'hDEADBEEF, 32'h0,        0, 1));
    vt.push_back(mk(0, 0, 3'b010, 9'h010, 32'h0,        32'hDEADBEEF, 0, 1));
    vt.push_back(mk(0, 1, 3'b000, 9'h013, 32'h00000080, 32'h0,        0, 1));
    vt.push_back(mk(0, 0, 3'b000, 9'h013, 32'h0,        32'hFFFFFF80, 0, 1));
    vt.push_back(mk(0, 0, 3'b100, 9'h013, 32'h0,        32'h00000080, 0, 1));
    vt.push_back(mk(0, 0, 3'b010, 9'h010, 32'h0,        32'h80ADBEEF, 0, 1));
    vt.push_back(mk(0, 0, 3'b001, 9'h011, 32'h0,        32'hFFFFADBE, 0, 1));
    vt.push_back(mk(0, 1, 3'b010, 9'h004, 32'h55667788, 32'h0,        0, 1));
    vt.push_back(mk(0, 1, 3'b010, 9'h008, 32'hCAFEF00D, 32'h0,        0, 1));
    vt.push_back(mk(0, 1, 3'b010, 9'h006, 32'h11223344, 32'h0,        0, 2));
    vt.push_back(mk(0, 0, 3'b010, 9'h006, 32'h0,        32'h11223344, 0, 2));
    vt.push_back(mk(0, 0, 3'b010, 9'h004, 32'h0,        32'h33447788, 0, 1));
    vt.push_back(mk(0, 0, 3'b101, 9'h008, 32'h0,        32'h00001122, 0, 1));
    vt.push_back(mk(0, 0, 3'b010, 9'h008, 32'h0,        32'hCAFE1122, 0, 1));
    vt.push_back(mk(0, 1, 3'b001, 9'h1FF, 32'h0000A5C3, 32'h0,        0, 2));
    vt.push_back(mk(0, 0, 3'b001, 9'h1FF, 32'h0,        32'hFFFFA5C3, 0, 2));
    vt.push_back(mk(0, 0, 3'b100, 9'h000, 32'h0,        32'h000000A5, 0, 1));
    vt.push_back(mk(0, 0, 3'b100, 9'h1FF, 32'h0,        32'h000000C3, 0, 1));
    vt.push_back(mk(0, 1, 3'b011, 9'h010, 32'h12345678, 32'h0,        1, 1));
    vt.push_back(mk(0, 0, 3'b110, 9'h010, 32'h0,        32'h0,        1, 1));
    vt.push_back(mk(0, 0, 3'b010, 9'h010, 32'h0,        32'h80ADBEEF, 0, 1));
    // strict DUT (MISALIGN_SPLIT=0)
    vt.push_back(mk(1, 1, 3'b010, 9'h020, 32'h12345678, 32'h0,        0, 1));
    vt.push_back(mk(1, 0, 3'b010, 9'h020, 32'h0,        32'h12345678, 0, 1));
    vt.push_back(mk(1, 0, 3'b101, 9'h022, 32'h0,        32'h00001234, 0, 1));
    vt.push_back(mk(1, 0, 3'b001, 9'h021, 32'h0,        32'h0,        1, 1));
    vt.push_back(mk(1, 0, 3'b010, 9'h002, 32'h0,        32'h0,        1, 1));
    vt.push_back(mk(1, 1, 3'b010, 9'h022, 32'hFFFFFFFF, 32'h0,        1, 1));
    vt.push_back(mk(1, 0, 3'b010, 9'h020, 32'h0,        32'h12345678, 0, 1));

    // reset state, with req_valid asserted during reset
    @(negedge clk); v0 = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'b0, rr0}, 32'h0);
    chk("rst_rsp_valid", {31'b0, rv0}, 32'h0);
    chk("rst_rsp_rdata", rd0, 32'h0);
    chk("rst_rsp_err",   {31'b0, re0}, 32'h0);
    v0 = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rsp_valid", {31'b0, rv0}, 32'h0);
    chk("post_rst_req_ready", {31'b0, rr0}, 32'h1);

    foreach (vt[i]) begin
      xact(vt[i].which, vt[i].we, vt[i].f3, vt[i].addr, vt[i].wd, grd, gerr, glat);
      chk($sformatf("vec%0d_rdata", i), grd, vt[i].exp_rd);
      chk($sformatf("vec%0d_err", i), {31'b0, gerr}, {31'b0, vt[i].exp_err});
      chk($sformatf("vec%0d_lat", i), glat, vt[i].exp_lat);
    end

    // back-to-back loads, one per cycle
    @(negedge clk);
    we = 1'b0; f3 = 3'b010; addr = 9'h010; v0 = 1'b1;
    @(posedge clk); #1 addr = 9'h004;
    @(negedge clk);
    chk("b2b_rsp_valid1", {31'b0, rv0}, 32'h1);
    chk("b2b_rdata1", rd0, 32'h80ADBEEF);
    chk("b2b_req_ready", {31'b0, rr0}, 32'h1);
    @(posedge clk); #1 v0 = 1'b0;
    @(negedge clk);
    chk("b2b_rsp_valid2", {31'b0, rv0}, 32'h1);
    chk("b2b_rdata2", rd0, 32'h33447788);

    // backpressure: response held for 3 cycles
    @(negedge clk);
    rsp_ready = 1'b0; we = 1'b0; f3 = 3'b010; addr = 9'h010; v0 = 1'b1;
    @(posedge clk); #1 v0 = 1'b0; addr = 9'h004;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_rsp_valid", k), {31'b0, rv0}, 32'h1);
      chk($sformatf("bp%0d_rdata", k), rd0, 32'h80ADBEEF);
      chk($sformatf("bp%0d_req_ready", k), {31'b0, rr0}, 32'h0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_released", {31'b0, rv0}, 32'h0);

    // reset in the BEAT2 cycle of a crossing store
    @(negedge clk);
    we = 1'b1; f3 = 3'b010; addr = 9'h006; wd = 32'hAABBCCDD; v0 = 1'b1;
    @(posedge clk); #1 v0 = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("b2rst_rsp_valid", {31'b0, rv0}, 32'h0);
    xact(0, 0, 3'b010, 9'h004, 32'h0, grd, gerr, glat);
    chk("b2rst_word1", grd, 32'hCCDD7788);
    xact(0, 0, 3'b010, 9'h008, 32'h0, grd, gerr, glat);
    chk("b2rst_word2", grd, 32'hCAFE1122);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Parametrised load/store data memory for the single-path RISC-V core. It replaces the combinational-control data memory with a valid/ready request/response interface and a registered synchronous-read word array. It supports all RV32 load/store widths with sign and zero extension, and splits misaligned accesses that cross a word boundary into two beats. It sits between the ALU/address stage and writeback.

## Interface
Parameters:
- ADDR_W, 9, byte-address width; array holds 2**(ADDR_W-2) 32-bit words
- MISALIGN_SPLIT, 1, 1 = execute misaligned accesses (two beats if word-crossing); 0 = return error for any misaligned access

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  instruction bits 14:12 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  illegal funct3 or misaligned access with MISALIGN_SPLIT=0

## Operation
- Access size: funct3[1:0] gives size. 00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes; 11 is illegal. Loads with funct3[2]=1 zero-extend. Legal load funct3 values are 000, 001, 010, 100, 101. Legal store funct3 values are 000, 001, 010.
- Byte offset off = addr[1:0], word index w = addr[ADDR_W-1:2].
- Crossing access: off + size > 4. It needs word w and word w+1. The index wraps from the last word to word 0.
- Store: each beat writes only the byte lanes covered, using a byte enable derived from the shifted mask. Data is req_wdata shifted left by 8*off across a 64-bit {hi,lo} pair.
- Load: the beat words are captured into lo/hi registers. Result = ({hi,lo} >> 8*off), truncated to size, then sign/zero extended.
- Error request: MISALIGN_SPLIT=0 and the access is not naturally aligned, or funct3 is illegal. Effect: no array write, rsp_err=1, rsp_rdata=0, single-beat timing.
- FSM states:
  - IDLE: req_ready=1. On accept, go to BEAT2 if crossing and legal, else to RESP.
  - BEAT2: access word w+1, req_ready=0, then go to RESP.
  - RESP: rsp_valid=1. If rsp_ready and a new request is accepted in the same cycle (req_ready=rsp_ready), take the IDLE accept transitions. If rsp_ready only, go to IDLE. Otherwise hold the response stable.
- Request fields are latched at accept. Inputs are ignored outside accept cycles.

## Timing
- Reset values: state IDLE, req_ready 0 while rst=1, rsp_valid 0, rsp_rdata 0, rsp_err 0, lo/hi 0. Array contents are not reset.
- Non-crossing access accepted in cycle T: store write commits at the end of T, and rsp_valid is high in T+1.
- Crossing access accepted in T: beat 1 (word w) in T, beat 2 (word w+1) in T+1, rsp_valid in T+2.
- Back-to-back throughput with rsp_ready tied high: one non-crossing request every cycle.
- Read-after-write to the same word in consecutive accepts returns the new data. The array is write-first, or a bypass provides the same result.
- rsp_valid/rsp_rdata/rsp_err remain stable until rsp_ready.
- Reset mid-operation: the FSM returns to IDLE and any pending response is dropped. If reset is asserted in the BEAT2 cycle of a crossing store, the beat-2 write is suppressed and the beat-1 bytes remain written.
- Simultaneous rst and req_valid: reset wins and nothing is accepted.

## Structure
- Package dmem_pkg holds:
  - funct3 enum (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - FSM state enum (S_IDLE, S_BEAT2, S_RESP)
  - size decode function
  - byte-mask function
- Sub-module dmem_bank contains the word array: 2**(ADDR_W-2) x 32, 4-bit byte enable, one synchronous read/write port, write-first.
- dmem_lsu contains the FSM, the lane shifting/extension logic and the response registers.

## Test plan
- Aligned word: SW addr 0x010 data 0xDEADBEEF, then LW 0x010 -> rsp_rdata 0xDEADBEEF, rsp_err 0, each response one cycle after accept.
- Byte extension: SB 0x013 data 0x80, then LB 0x013 -> 0xFFFFFF80; LBU 0x013 -> 0x00000080; bytes 0x010-0x012 unchanged (LW 0x010 -> 0x80ADBEEF).
- Crossing split (MISALIGN_SPLIT=1): SW 0x006 data 0x11223344, then LW 0x006 -> 0x11223344 with rsp_valid two cycles after accept; LW 0x004 -> 0x3344xxxx from prior contents, LHU 0x008 -> 0x00001122.
- Wrap-around (ADDR_W=9): SH 0x1FF data 0xA5C3 -> byte 0x1FF=0xC3, byte 0x000=0xA5; LH 0x1FF -> 0xFFFFA5C3.
- Error path: MISALIGN_SPLIT=0 with LW 0x002 -> rsp_err 1, rsp_rdata 0; illegal funct3 3'b011 store -> rsp_err 1, memory unchanged.
- Backpressure/reset: hold rsp_ready=0 for 3 cycles -> response stable and req_ready 0; assert rst in the BEAT2 cycle of SW 0x006 -> rsp_valid 0 next cycle, only bytes 0x006-0x007 updated.
